// File: rtl/axi4l_gpio_pkg.sv
// Shared register-map constants, response codes and index helpers for the
// AXI4-Lite GPIO slave.
package axi4l_gpio_pkg;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t IDX_DATA_OUT   = 3'd0;
    localparam reg_idx_t IDX_DIR        = 3'd1;
    localparam reg_idx_t IDX_DATA_IN    = 3'd2;
    localparam reg_idx_t IDX_INT_STATUS = 3'd3;
    localparam reg_idx_t IDX_INT_MASK   = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Indices 5..7 are undecoded and answer with SLVERR.
    function automatic logic idx_decoded(input reg_idx_t idx);
        return idx <= IDX_INT_MASK;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous GPIO pins, plus a one-cycle pulse
// on every rising edge of the synchronised value.
module gpio_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/axi4l_gpio_slave.sv
// AXI4-Lite GPIO register slave (DATA_OUT, DIR, DATA_IN, INT_STATUS, INT_MASK).
// Define GPIO_IRQ_EN to build the rising-edge interrupt unit.
module axi4l_gpio_slave
    import axi4l_gpio_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    input  logic [GPIO_WIDTH-1:0]   gpio_in_i,
    output logic [GPIO_WIDTH-1:0]   gpio_out_o,
    output logic [GPIO_WIDTH-1:0]   gpio_oe_o,
    output logic                    irq_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  live_q;
    logic                  aw_held_q;
    reg_idx_t              aw_idx_q;
    logic                  w_held_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_fire;
    reg_idx_t              wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, wr_mask, rd_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [GPIO_WIDTH-1:0] gpio_wdata, gpio_mask;
    logic [GPIO_WIDTH-1:0] data_in, gpio_rise;
    logic                  unused_bits;

    gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (gpio_in_i),
        .q_o    (data_in),
        .rise_o (gpio_rise)
    );

    // live_q keeps every READY low until the first edge after reset release.
    assign awready_o = live_q & ~aw_held_q & ~bvalid_q;
    assign wready_o  = live_q & ~w_held_q & ~bvalid_q;
    assign arready_o = live_q & ~rvalid_q;

    assign aw_hs = awvalid_i & awready_o;
    assign w_hs  = wvalid_i & wready_o;
    assign b_hs  = bvalid_q & bready_i;
    assign ar_hs = arvalid_i & arready_o;
    assign r_hs  = rvalid_q & rready_i;

    assign wr_idx  = aw_held_q ? aw_idx_q : awaddr_i[4:2];
    assign wr_data = w_held_q ? wdata_q : wdata_i;
    assign wr_strb = w_held_q ? wstrb_q : wstrb_i;
    assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign rd_idx  = araddr_i[4:2];

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
        end
    end

    assign gpio_wdata = wr_data[GPIO_WIDTH-1:0];
    assign gpio_mask  = wr_mask[GPIO_WIDTH-1:0];

    // Holding registers stay occupied while the response is outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            live_q <= 1'b1;
            if (b_hs) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= awaddr_i[4:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= wdata_i;
                    wstrb_q  <= wstrb_i;
                end
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= idx_decoded(wr_idx) ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (wr_fire) begin
            case (wr_idx)
                IDX_DATA_OUT: data_out_d = (data_out_q & ~gpio_mask) | (gpio_wdata & gpio_mask);
                IDX_DIR:      dir_d      = (dir_q & ~gpio_mask) | (gpio_wdata & gpio_mask);
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_out_q <= '0;
            dir_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] int_status_q, int_status_d;
    logic [GPIO_WIDTH-1:0] int_mask_q, int_mask_d;
    logic                  irq_q;

    // A new edge is OR-ed in after the W1C clear, so a coincident set wins.
    always_comb begin
        int_status_d = int_status_q;
        int_mask_d   = int_mask_q;
        if (wr_fire && wr_idx == IDX_INT_STATUS) begin
            int_status_d = int_status_q & ~(gpio_wdata & gpio_mask);
        end
        if (wr_fire && wr_idx == IDX_INT_MASK) begin
            int_mask_d = (int_mask_q & ~gpio_mask) | (gpio_wdata & gpio_mask);
        end
        int_status_d = int_status_d | gpio_rise;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_status_q <= '0;
            int_mask_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            int_status_q <= int_status_d;
            int_mask_q   <= int_mask_d;
            irq_q        <= |(int_status_q & int_mask_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (rd_idx)
            IDX_DATA_OUT:   rd_data = DATA_WIDTH'(data_out_q);
            IDX_DIR:        rd_data = DATA_WIDTH'(dir_q);
            IDX_DATA_IN:    rd_data = DATA_WIDTH'(data_in);
`ifdef GPIO_IRQ_EN
            IDX_INT_STATUS: rd_data = DATA_WIDTH'(int_status_q);
            IDX_INT_MASK:   rd_data = DATA_WIDTH'(int_mask_q);
`endif
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= idx_decoded(rd_idx) ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_data;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bvalid_o   = bvalid_q;
    assign bresp_o    = bresp_q;
    assign rvalid_o   = rvalid_q;
    assign rresp_o    = rresp_q;
    assign rdata_o    = rdata_q;
    assign gpio_out_o = data_out_q;
    assign gpio_oe_o  = dir_q;

    assign unused_bits = ^{awaddr_i, araddr_i, wr_data, wr_mask, gpio_rise};

endmodule

// File: doc/axi4l_gpio_slave.md
# axi4l_gpio_slave

AXI4-Lite slave that exposes a parametrised GPIO register file (output data, direction, synchronised input, interrupt status/mask) to the bus side of the GPIO framework. Write and read channels are fully decoupled, with independent AW/W acceptance, byte strobes and error responses for undecoded addresses. Pin-side inputs pass through a two-flop synchroniser. An optional rising-edge interrupt unit is included.

## Interface
- ADDR_WIDTH, 32: AXI address width (>= 5).
- DATA_WIDTH, 32: AXI data width, 32 or 64.
- GPIO_WIDTH, 32: number of GPIO pins, 1..DATA_WIDTH.
- clk  input  1  bus and pin clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels; widths per ADDR_WIDTH/DATA_WIDTH, WSTRB DATA_WIDTH/8, BRESP 2.
- ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels; RRESP 2.
- gpio_in   input   GPIO_WIDTH  asynchronous pin inputs.
- gpio_out  output  GPIO_WIDTH  DATA_OUT register.
- gpio_oe   output  GPIO_WIDTH  DIR register; 1 = drive.
- irq       output  1  level interrupt; registered.

## Operation
- Register map, word index = ADDR[4:2], ADDR[1:0] ignored:
  - 0 DATA_OUT (RW)
  - 1 DIR (RW)
  - 2 DATA_IN (RO)
  - 3 INT_STATUS (W1C)
  - 4 INT_MASK (RW)
- Register bits above GPIO_WIDTH read 0 and ignore writes. Address bits above [4:2] are not decoded; addresses alias every 32 bytes.
- Index 5..7: write discarded, BRESP=2'b10 (SLVERR); read returns RDATA=0, RRESP=2'b10.
- Write to DATA_IN: ignored, BRESP=OKAY.
- Write channel:
  - AW and W are captured into separate one-entry holding registers, in either order or in the same cycle.
  - AWREADY = AW holding empty and !BVALID; WREADY = W holding empty and !BVALID.
  - When both are held, the register update applies per WSTRB byte lane and BVALID rises the next cycle.
  - BVALID and BRESP hold until BREADY; both holding registers then clear.
- Read channel:
  - ARREADY = !RVALID.
  - On handshake, RDATA/RRESP are registered and RVALID rises the next cycle; all hold until RREADY.
- Read and write are independent. A read handshake in the same cycle as the write update returns the pre-write value.
- DATA_IN = gpio_in after the two-flop synchroniser.

## Timing
- Reset values:
  - AWREADY=0, WREADY=0, ARREADY=0 while rst low; each rises the first cycle after release.
  - BVALID=0, BRESP=0, RVALID=0, RDATA=0, RRESP=0.
  - gpio_out=0, gpio_oe=0, irq=0; all registers 0.
- Write latency: BVALID asserts 1 cycle after the later of the AW/W handshakes. gpio_out/gpio_oe change in that same cycle.
- Read latency: RVALID asserts 1 cycle after the AR handshake. Back-to-back throughput is one transfer per 2 cycles per channel.
- gpio_in to DATA_IN: 2 cycles. DATA_IN to INT_STATUS set: 1 cycle. INT_STATUS to irq: 1 cycle.
- Reset asserted mid-transaction: all holding registers and valids clear immediately; no partial write is applied afterwards.
- VALID signals are never withdrawn before their handshake. READY may be high without a pending VALID.

## Configuration
- GPIO_IRQ_EN defined:
  - A synchronised-input rising edge sets the corresponding INT_STATUS bit.
  - Writing 1 clears a bit; a set in the same cycle wins over the clear.
  - irq = |(INT_STATUS & INT_MASK), registered.
- GPIO_IRQ_EN undefined:
  - Indices 3 and 4 read 0 with OKAY and ignore writes.
  - irq is tied 0; no edge-detect logic is present.

## Structure
- Package axi4l_gpio_pkg:
  - Register index constants.
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Register-index typedef.
- Sub-module gpio_sync: parametrised-width two-flop synchroniser plus one-cycle rising-edge pulse output. The edge output is unused without GPIO_IRQ_EN.

## Test plan
- Reset, then write 0x0000_00A5 to index 0 with WSTRB=4'hF and AW one cycle before W -> BRESP=0 two cycles after AW; gpio_out=0xA5; read back 0xA5 with OKAY.
- Write 0xFFFF_FFFF to index 1 with WSTRB=4'b0010, W before AW, BREADY held low 3 cycles -> gpio_oe=0x0000_FF00; BVALID stable 3 cycles; AWREADY/WREADY low until BREADY.
- Drive gpio_in=0x0F -> read of index 2 returns 0x0F no earlier than 2 cycles after the change; a write of 0 to index 2 returns OKAY with no effect.
- Access index 6 (address 0x18), write and read -> BRESP=2'b10, RRESP=2'b10, RDATA=0; no register changes.
- With GPIO_IRQ_EN, INT_MASK=0x1: a rising edge on gpio_in[0] gives INT_STATUS=0x1 and irq=1 four cycles after the pin edge. W1C 0x1 -> irq=0. W1C coincident with a new edge -> bit stays 1.
- Reset asserted while AW is held and W is pending -> BVALID=0, no gpio_out change, READYs return high after release.
